div_iter_unit: RTL and testbench

- Iterative radix-2 restoring divider for the MIPS DIV/DIVU instructions.
- Sits beside the multiplier in the EX/MEM region and drives the div_hi, div_low and div_complete inputs of the MEM/WB pipeline register, which captures HI/LO.
- Computes one quotient bit per cycle.
- Supports pipeline flush via cancel, for exceptions and ERET.

---
 rtl/div_iter_unit.sv | 181 ++++++++++++++++++
 tb/tb_div_iter_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Feeds HI/LO of the MEM/WB register; cancel aborts for flushes.
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             div_busy,
  output logic             div_complete,
  output logic [WIDTH-1:0] div_low,
  output logic [WIDTH-1:0] div_hi
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             cmpl_q, cmpl_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    if (div_signed && dividend[WIDTH-1]) begin
      dvd_mag = -dividend;
    end
    if (div_signed && divisor[WIDTH-1]) begin
      dvs_mag = -divisor;
    end
  end

  // Shifted partial remainder is WIDTH+1 bits so the trial
  // subtract borrow lands in the top bit.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    borrow = trial[WIDTH];
    rem_nx = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    quo_fix = quo_nx;
    rem_fix = rem_nx;
    if (sgn_q && qneg_q) begin
      quo_fix = -quo_nx;
    end
    if (sgn_q && rneg_q) begin
      rem_fix = -rem_nx;
    end
    if (dz_q) begin
      quo_fix = '1;
      rem_fix = raw_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    low_d   = low_q;
    hi_d    = hi_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (div_start && !cancel) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          raw_d   = dividend;
          sgn_d   = div_signed;
          qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d  = dividend[WIDTH-1];
          dz_d    = (divisor == '0);
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            low_d   = quo_fix;
            hi_d    = rem_fix;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    cmpl_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      low_q   <= '0;
      hi_q    <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      cmpl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      low_q   <= low_d;
      hi_q    <= hi_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      cmpl_q  <= cmpl_d;
    end
  end

  assign div_busy     = busy_q;
  assign div_complete = cmpl_q;
  assign div_low      = low_q;
  assign div_hi       = hi_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Bench for div_iter_unit: directed cases plus randomized ops
// checked every cycle against an arithmetic reference model.
module tb_div_iter_unit;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         div_start;
  logic         div_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         cancel;
  logic         div_busy;
  logic         div_complete;
  logic [W-1:0] div_low;
  logic [W-1:0] div_hi;

  int n_chk  = 0;
  int n_fail = 0;

  div_iter_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .cancel      (cancel),
    .div_busy    (div_busy),
    .div_complete(div_complete),
    .div_low     (div_low),
    .div_hi      (div_hi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input bit sg, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] lo,
                                  output logic [W-1:0] hi);
    longint sa, sb, q, r;
    if (b == '0) begin
      lo = '1;
      hi = a;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Reference: an accepted op completes WIDTH edges later, then one
  // cycle of DONE during which cancel is ignored.
  bit           m_valid = 0;
  bit           m_busy  = 0;
  bit           m_done  = 0;
  int           m_left  = 0;
  logic [W-1:0] m_low   = '0;
  logic [W-1:0] m_hi    = '0;
  logic [W-1:0] p_low, p_hi;

  always @(posedge clock) begin
    m_valid = 1;
    if (reset) begin
      m_busy = 0;
      m_done = 0;
      m_low  = '0;
      m_hi   = '0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_busy) begin
      if (cancel) begin
        m_busy = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_low  = p_low;
          m_hi   = p_hi;
        end
      end
    end else if (div_start && !cancel) begin
      m_busy = 1;
      m_left = W;
      ref_div(div_signed, dividend, divisor, p_low, p_hi);
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("busy", W'(div_busy), W'(m_busy));
      check("complete", W'(div_complete), W'(m_done));
      check("low", div_low, m_low);
      check("hi", div_hi, m_hi);
    end
  end

  task automatic start_op(input bit sg, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    @(posedge clock);
    #1;
    div_start  = 1'b1;
    div_signed = sg;
    dividend   = a;
    divisor    = b;
    @(posedge clock);
    #1;
    div_start = 1'b0;
  endtask

  task automatic wait_idle(output int bc, output int pc,
                           output logic [W-1:0] lo,
                           output logic [W-1:0] hi);
    bit fin;
    bc  = 0;
    pc  = 0;
    lo  = div_low;
    hi  = div_hi;
    fin = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (div_complete) begin
        pc++;
        lo = div_low;
        hi = div_hi;
      end
      if (!div_busy) begin
        fin = 1;
        break;
      end
      bc++;
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got busy expected idle within 200 cycles");
    end
  endtask

  task automatic run(input string nm, input bit sg,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] elo, input logic [W-1:0] ehi);
    int bc, pc;
    logic [W-1:0] lo, hi;
    start_op(sg, a, b);
    wait_idle(bc, pc, lo, hi);
    check({nm, "_busycyc"}, W'(bc), 32'd33);
    check({nm, "_pulses"}, W'(pc), 32'd1);
    check({nm, "_lo"}, lo, elo);
    check({nm, "_hi"}, hi, ehi);
  endtask

  task automatic pin_model(input string nm, input bit sg,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] elo, input logic [W-1:0] ehi);
    logic [W-1:0] lo, hi;
    ref_div(sg, a, b, lo, hi);
    check({nm, "_mlo"}, lo, elo);
    check({nm, "_mhi"}, hi, ehi);
  endtask

  initial begin
    int bc, pc, k, sel;
    bit sg;
    logic [W-1:0] a, b, lo, hi;

    reset      = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    cancel     = 1'b0;

    pin_model("m_divu", 0, 32'd100, 32'd7, 32'h0000000E, 32'h2);
    pin_model("m_neg7", 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    pin_model("m_7neg", 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1);
    pin_model("m_ovf", 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
    pin_model("m_dz", 1, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF0);

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", W'(div_busy), 32'd0);
    check("rst_low", div_low, 32'd0);
    check("rst_hi", div_hi, 32'd0);

    run("divu100_7", 0, 32'd100, 32'd7, 32'h0000000E, 32'h2);
    run("div_m7_2", 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run("div_7_m2", 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1);
    run("div_ovf", 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
    run("divu_ovf", 0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run("divu_dz", 0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678);
    run("div_dz", 1, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF0);

    start_op(0, 32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #1;
    cancel = 1'b1;
    @(posedge clock);
    #1;
    cancel = 1'b0;
    wait_idle(bc, pc, lo, hi);
    check("cancel_pulses", W'(pc), 32'd0);
    check("cancel_low", div_low, 32'hFFFFFFFF);
    check("cancel_hi", div_hi, 32'hFFFFFFF0);
    run("divu9_3", 0, 32'd9, 32'd3, 32'd3, 32'd0);

    start_op(0, 32'd100, 32'd7);
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_idle(bc, pc, lo, hi);
    check("rstmid_pulses", W'(pc), 32'd0);
    check("rstmid_busy", W'(div_busy), 32'd0);
    check("rstmid_low", div_low, 32'd0);
    check("rstmid_hi", div_hi, 32'd0);

    @(posedge clock);
    #1;
    div_start = 1'b1;
    cancel    = 1'b1;
    @(posedge clock);
    #1;
    div_start = 1'b0;
    cancel    = 1'b0;
    @(negedge clock);
    check("startcancel_busy", W'(div_busy), 32'd0);

    @(posedge clock);
    #1;
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    @(posedge clock);
    #1;
    dividend = 32'd50;
    divisor  = 32'd5;
    repeat (20) @(posedge clock);
    #1;
    div_start = 1'b0;
    wait_idle(bc, pc, lo, hi);
    check("hold_pulses", W'(pc), 32'd1);
    check("hold_lo", lo, 32'h0000000E);
    check("hold_hi", hi, 32'h2);

    for (int i = 0; i < 150; i++) begin
      sg  = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: begin a = 32'h80000000; b = '1; end
        2: b = W'($urandom_range(1, 15));
        3: a = W'($urandom_range(0, 15));
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      start_op(sg, a, b);
      k = $urandom_range(0, 9);
      if (k == 0) begin
        repeat ($urandom_range(0, 32)) @(posedge clock);
        #1;
        cancel = 1'b1;
        @(posedge clock);
        #1;
        cancel = 1'b0;
      end else if (k == 1) begin
        for (int j = 0; j < 60; j++) begin
          @(negedge clock);
          if (div_complete) break;
        end
        cancel = 1'b1;
        @(posedge clock);
        #1;
        cancel = 1'b0;
      end
      wait_idle(bc, pc, lo, hi);
    end

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
